// File: rtl/rx_burst_pkg.sv
// Shared definitions for the GMSK burst receiver: FSM states, PRBS generator
// and the sync word / LFSR state derived from the common seed.
package rx_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_PAYLOAD,
    ST_REPORT
  } state_e;

  localparam logic [7:0]  LFSR_TAPS        = 8'h2d;
  localparam logic [7:0]  LFSR_SEED        = 8'h01;
  localparam int unsigned SYNC_LEN_DEFAULT = 16;

  // Galois step: shift right, fold taps in when the bit shifted out was 1.
  function automatic logic [7:0] prbs_step(input logic [7:0] s);
    return s[0] ? ({1'b0, s[7:1]} ^ LFSR_TAPS) : {1'b0, s[7:1]};
  endfunction

  // First len lfsr[1] outputs from the seed, oldest in the most significant bit.
  function automatic logic [31:0] sync_word_calc(input int unsigned len);
    logic [7:0]  s;
    logic [31:0] w;
    s = LFSR_SEED;
    w = '0;
    for (int unsigned i = 0; i < len; i++) begin
      w = {w[30:0], s[1]};
      s = prbs_step(s);
    end
    return w;
  endfunction

  function automatic logic [7:0] sync_state_calc(input int unsigned len);
    logic [7:0] s;
    s = LFSR_SEED;
    for (int unsigned i = 0; i < len; i++) begin
      s = prbs_step(s);
    end
    return s;
  endfunction

  localparam logic [SYNC_LEN_DEFAULT-1:0] SYNC_WORD =
    SYNC_LEN_DEFAULT'(sync_word_calc(SYNC_LEN_DEFAULT));
  localparam logic [7:0] SYNC_STATE = sync_state_calc(SYNC_LEN_DEFAULT);

endpackage

// File: rtl/rx_burst_energy_detect.sv
// Carrier detector: |I|+|Q| against a threshold, with a run-length
// hysteresis so carrier_detect only flips after CD_HOLD agreeing samples.
module energy_detect #(
  parameter int unsigned SAMPLE_BITS   = 6,
  parameter int unsigned ENERGY_THRESH = 20,
  parameter int unsigned CD_HOLD       = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          sample_strobe,
  input  logic signed [SAMPLE_BITS-1:0] rf_inphase,
  input  logic signed [SAMPLE_BITS-1:0] rf_quadrature,
  output logic                          carrier_detect
);

  localparam int unsigned MW = SAMPLE_BITS + 1;
  localparam int unsigned RW = $clog2(CD_HOLD + 1);

  // One extra bit so the most negative sample maps to a positive magnitude.
  function automatic logic [MW-1:0] mag_abs(input logic signed [SAMPLE_BITS-1:0] x);
    logic [MW-1:0] e;
    e = {x[SAMPLE_BITS-1], x};
    return x[SAMPLE_BITS-1] ? (~e + MW'(1)) : e;
  endfunction

  logic [MW-1:0] mag_d, mag_q;
  logic          mag_vld_d, mag_vld_q;
  logic          side_d, side_q;
  logic          cd_d, cd_q;
  logic [RW-1:0] run_d, run_q;
  logic          above;

  always_comb begin
    mag_d     = mag_q;
    mag_vld_d = sample_strobe;
    side_d    = side_q;
    run_d     = run_q;
    cd_d      = cd_q;
    above     = (mag_q >= MW'(ENERGY_THRESH));
    if (sample_strobe) begin
      mag_d = mag_abs(rf_inphase) + mag_abs(rf_quadrature);
    end
    if (mag_vld_q) begin
      side_d = above;
      if (above != side_q) begin
        run_d = RW'(1);
      end else if (run_q != RW'(CD_HOLD)) begin
        run_d = run_q + RW'(1);
      end
      if (run_d == RW'(CD_HOLD) && side_d != cd_q) begin
        cd_d = side_d;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mag_q     <= '0;
      mag_vld_q <= 1'b0;
      side_q    <= 1'b0;
      run_q     <= '0;
      cd_q      <= 1'b0;
    end else begin
      mag_q     <= mag_d;
      mag_vld_q <= mag_vld_d;
      side_q    <= side_d;
      run_q     <= run_d;
      cd_q      <= cd_d;
    end
  end

  assign carrier_detect = cd_q;

endmodule

// File: rtl/rx_burst.sv
// Burst receiver: carrier detect, sync-word search over demodulated symbols,
// PRBS payload error counting and per-burst reporting.
module rx_burst #(
  parameter int unsigned SAMPLE_BITS   = 6,
  parameter int unsigned ENERGY_THRESH = 20,
  parameter int unsigned CD_HOLD       = 8,
  parameter int unsigned SYNC_LEN      = 16,
  parameter int unsigned BURST_SYMBOLS = 40,
  parameter int unsigned SEARCH_WINDOW = 64,
  parameter int unsigned MAX_ERRORS    = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          sample_strobe,
  input  logic signed [SAMPLE_BITS-1:0] rf_inphase,
  input  logic signed [SAMPLE_BITS-1:0] rf_quadrature,
  input  logic                          demod_symbol_strobe,
  input  logic                          demod_symbol,
  output logic                          carrier_detect,
  output logic                          in_burst,
  output logic                          burst_done,
  output logic                          burst_ok,
  output logic                          burst_aborted,
  output logic                          sync_timeout,
  output logic [7:0]                    bit_errors,
  output logic [15:0]                   burst_count
);

  import rx_burst_pkg::*;

  localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_LEN'(sync_word_calc(SYNC_LEN));
  localparam logic [7:0]          SYNC_LFSR    = sync_state_calc(SYNC_LEN);
  localparam int unsigned         SCW          = $clog2(SEARCH_WINDOW + 1);
  localparam int unsigned         YCW          = $clog2(BURST_SYMBOLS);

  logic carrier;

  energy_detect #(
    .SAMPLE_BITS  (SAMPLE_BITS),
    .ENERGY_THRESH(ENERGY_THRESH),
    .CD_HOLD      (CD_HOLD)
  ) u_energy (
    .clock         (clock),
    .reset         (reset),
    .sample_strobe (sample_strobe),
    .rf_inphase    (rf_inphase),
    .rf_quadrature (rf_quadrature),
    .carrier_detect(carrier)
  );

  state_e              state_d, state_q;
  logic [SCW-1:0]      search_cnt_d, search_cnt_q, search_next;
  logic [YCW-1:0]      sym_cnt_d, sym_cnt_q;
  logic [7:0]          lfsr_d, lfsr_q;
  logic [SYNC_LEN-1:0] sync_sr_d, sync_sr_q;
  logic                cd_prev_q;
  logic                in_burst_d, in_burst_q;
  logic                burst_done_d, burst_done_q;
  logic                burst_ok_d, burst_ok_q;
  logic                burst_aborted_d, burst_aborted_q;
  logic                sync_timeout_d, sync_timeout_q;
  logic [7:0]          bit_errors_d, bit_errors_q;
  logic [15:0]         burst_count_d, burst_count_q;

  always_comb begin
    state_d         = state_q;
    search_cnt_d    = search_cnt_q;
    sym_cnt_d       = sym_cnt_q;
    lfsr_d          = lfsr_q;
    in_burst_d      = in_burst_q;
    burst_ok_d      = burst_ok_q;
    bit_errors_d    = bit_errors_q;
    burst_count_d   = burst_count_q;
    burst_done_d    = 1'b0;
    burst_aborted_d = 1'b0;
    sync_timeout_d  = 1'b0;
    search_next     = search_cnt_q + SCW'(1);
    sync_sr_d       = demod_symbol_strobe ? {sync_sr_q[SYNC_LEN-2:0], demod_symbol} : sync_sr_q;

    case (state_q)
      ST_IDLE: begin
        if (carrier && !cd_prev_q) begin
          state_d      = ST_SEARCH;
          search_cnt_d = '0;
        end
      end
      ST_SEARCH: begin
        if (demod_symbol_strobe) begin
          search_cnt_d = search_next;
        end
        // Match is tested before the window limit so a last-strobe sync still locks.
        if (demod_symbol_strobe && sync_sr_d == SYNC_PATTERN) begin
          state_d      = ST_PAYLOAD;
          lfsr_d       = SYNC_LFSR;
          sym_cnt_d    = YCW'(SYNC_LEN);
          bit_errors_d = '0;
          in_burst_d   = 1'b1;
        end else if (demod_symbol_strobe && search_next == SCW'(SEARCH_WINDOW)) begin
          sync_timeout_d = 1'b1;
          state_d        = ST_IDLE;
        end else if (!carrier) begin
          state_d = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (demod_symbol_strobe) begin
          if (demod_symbol != lfsr_q[1] && bit_errors_q != 8'hFF) begin
            bit_errors_d = bit_errors_q + 8'd1;
          end
          lfsr_d    = prbs_step(lfsr_q);
          sym_cnt_d = sym_cnt_q + YCW'(1);
        end
        // Final symbol takes priority over a simultaneous carrier drop.
        if (demod_symbol_strobe && sym_cnt_q == YCW'(BURST_SYMBOLS - 1)) begin
          state_d = ST_REPORT;
        end else if (!carrier) begin
          burst_aborted_d = 1'b1;
          in_burst_d      = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      ST_REPORT: begin
        burst_done_d  = 1'b1;
        burst_ok_d    = (bit_errors_q <= 8'(MAX_ERRORS));
        burst_count_d = burst_count_q + 16'd1;
        in_burst_d    = 1'b0;
        search_cnt_d  = '0;
        state_d       = carrier ? ST_SEARCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      search_cnt_q    <= '0;
      sym_cnt_q       <= '0;
      lfsr_q          <= LFSR_SEED;
      sync_sr_q       <= '0;
      cd_prev_q       <= 1'b0;
      in_burst_q      <= 1'b0;
      burst_done_q    <= 1'b0;
      burst_ok_q      <= 1'b0;
      burst_aborted_q <= 1'b0;
      sync_timeout_q  <= 1'b0;
      bit_errors_q    <= '0;
      burst_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      search_cnt_q    <= search_cnt_d;
      sym_cnt_q       <= sym_cnt_d;
      lfsr_q          <= lfsr_d;
      sync_sr_q       <= sync_sr_d;
      cd_prev_q       <= carrier;
      in_burst_q      <= in_burst_d;
      burst_done_q    <= burst_done_d;
      burst_ok_q      <= burst_ok_d;
      burst_aborted_q <= burst_aborted_d;
      sync_timeout_q  <= sync_timeout_d;
      bit_errors_q    <= bit_errors_d;
      burst_count_q   <= burst_count_d;
    end
  end

  assign carrier_detect = carrier;
  assign in_burst       = in_burst_q;
  assign burst_done     = burst_done_q;
  assign burst_ok       = burst_ok_q;
  assign burst_aborted  = burst_aborted_q;
  assign sync_timeout   = sync_timeout_q;
  assign bit_errors     = bit_errors_q;
  assign burst_count    = burst_count_q;

endmodule

// File: doc/rx_burst.md
Name: rx_burst

Overview:
- Receive-side counterpart of the GMSK burst transmitter.
- Takes I/Q samples from the RF chain to run carrier (energy) detection.
- Takes hard symbols from the GMSK demodulator, finds the burst sync word, and checks the PRBS payload against a local LFSR.
- Reports per-burst bit errors and pass/fail; sits between the demodulator and the link-test/statistics logic.

Parameters:
- SAMPLE_BITS, 6, width of signed I/Q samples (matches modulator output width).
- ENERGY_THRESH, 20, minimum |I|+|Q| counted as carrier.
- CD_HOLD, 8, consecutive samples needed to assert or drop carrier.
- SYNC_LEN, 16, sync symbols (first PRBS symbols from seed 8'h01).
- BURST_SYMBOLS, 40, total burst symbols (sync plus payload).
- SEARCH_WINDOW, 64, symbols allowed after carrier detect to find sync.
- MAX_ERRORS, 2, payload errors allowed for burst_ok.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_strobe  in  1  one valid I/Q sample this cycle.
- rf_inphase  in  SAMPLE_BITS  signed I sample.
- rf_quadrature  in  SAMPLE_BITS  signed Q sample.
- demod_symbol_strobe  in  1  demodulator hard symbol valid.
- demod_symbol  in  1  hard symbol value.
- carrier_detect  out  1  filtered energy-detect flag.
- in_burst  out  1  high from sync match until burst end or abort.
- burst_done  out  1  one-cycle pulse, full burst checked.
- burst_ok  out  1  valid on burst_done: bit_errors <= MAX_ERRORS.
- burst_aborted  out  1  one-cycle pulse, carrier lost mid-payload.
- sync_timeout  out  1  one-cycle pulse, no sync within SEARCH_WINDOW.
- bit_errors  out  8  payload mismatch count, held until next sync.
- burst_count  out  16  completed bursts, wrapping.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; LFSR = 8'h01; sync shift register = 0; counters = 0.
- Energy: mag = |I| + |Q|, computed unsigned in SAMPLE_BITS+1 bits so -32 gives 32 with no overflow. mag registered one cycle after sample_strobe.
  - Counter cd_run counts consecutive samples on the same side of ENERGY_THRESH (mag >= thresh counts as above).
  - carrier_detect toggles when cd_run reaches CD_HOLD with the opposite polarity.
  - Latency: CD_HOLD+1 strobes after the first qualifying sample.
- Symbols act only on demod_symbol_strobe. The sync shift register shifts in at every strobe, in all states, newest symbol at bit 0.
- FSM:
  - IDLE: carrier_detect rise -> SEARCH; search counter = 0.
  - SEARCH: each strobe increments the counter.
    - If the shifted-in register value equals SYNC_WORD -> PAYLOAD. Load LFSR = SYNC_STATE; sym counter = SYNC_LEN; bit_errors = 0; in_burst = 1.
    - Else if counter reaches SEARCH_WINDOW -> pulse sync_timeout, go to IDLE.
    - A match on the same strobe as the timeout wins.
    - Carrier drop -> IDLE with no pulse.
  - PAYLOAD: each strobe compares demod_symbol with lfsr[1].
    - A mismatch increments bit_errors, saturating at 255.
    - LFSR advances Galois-style: shift right with 0 in; if the old lsb is 1, XOR with 8'h2d.
    - Sym counter increments.
    - When sym counter reaches BURST_SYMBOLS-1 and that strobe is processed -> REPORT.
    - Carrier drop -> pulse burst_aborted, in_burst = 0, go to IDLE, bit_errors held.
    - A carrier drop on the same cycle as the final strobe counts as completion.
  - REPORT (one cycle): pulse burst_done; burst_ok = (bit_errors <= MAX_ERRORS); burst_count += 1, wrapping at 16'hFFFF -> 0; in_burst = 0.
    - Then go to SEARCH if carrier is still up (back-to-back bursts), else IDLE.
- burst_ok holds its value until the next burst_done.
- reset asserted in any state returns immediately to the reset values, including bit_errors and burst_count.

Decomposition:
- Package rx_burst_pkg holds:
  - the state enum;
  - LFSR_TAPS = 8'h2d and LFSR_SEED = 8'h01, shared with the transmitter;
  - the function prbs_step;
  - constants SYNC_WORD (first SYNC_LEN lfsr[1] outputs from the seed) and SYNC_STATE (LFSR after SYNC_LEN steps), both computed by package functions.
- One sub-module, energy_detect: |I|+|Q|, threshold, and CD_HOLD hysteresis.

Test Plan:
- Ten samples of I = 25, Q = 0 -> carrier_detect rises on cycle CD_HOLD+1 after the first strobe; seven such samples then noise -> stays 0.
- Carrier up, then SYNC_WORD followed by 24 correct PRBS symbols -> in_burst high for 24 strobes; burst_done pulse; bit_errors = 0; burst_ok = 1; burst_count = 1.
- Same burst with payload symbols 3, 9 and 20 inverted -> bit_errors = 3, burst_ok = 0.
- Carrier up with 64 random symbols containing no sync -> sync_timeout pulse on the 64th strobe; state back to IDLE.
- Carrier dropped after 10 payload symbols -> burst_aborted pulse, no burst_done, burst_count unchanged.
- reset asserted mid-PAYLOAD -> all outputs 0 asynchronously; a following clean burst reports bit_errors = 0.
